// File: rtl/leaf_user_rx_port_if.sv
// Handshake bundle between the leaf interface, the rx port and the user kernel.
//   dout_leaf_interface2user / vld_interface2user / ack_user2interface : leaf -> port
//   dout_user / vld_user / rdy_user                                      : port -> kernel
// Modports:
//   slave  : the rx port itself
//   master : the surrounding environment (leaf interface plus kernel)
interface leaf_user_rx_port_if #(
  parameter int unsigned PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;
  logic [PAYLOAD_BITS-1:0] dout_user;
  logic                    vld_user;
  logic                    rdy_user;

  modport slave (
    input  dout_leaf_interface2user,
    input  vld_interface2user,
    output ack_user2interface,
    output dout_user,
    output vld_user,
    input  rdy_user
  );

  modport master (
    output dout_leaf_interface2user,
    output vld_interface2user,
    input  ack_user2interface,
    input  dout_user,
    input  vld_user,
    output rdy_user
  );
endinterface

// File: rtl/leaf_user_rx_port.sv
// User-side receiver for one leaf input stream. Accepted words go into a
// first-word-fall-through FIFO with a registered head and are presented to the
// kernel through a valid/ready stream.
// Ports:
//   clk_user          : user clock, rising edge
//   reset             : asynchronous active-high reset
//   rx (slave)        : leaf handshake in, kernel stream out
//   level             : occupancy (storage + head), 0..2^DEPTH_BITS
//   afull             : occupancy >= 2^DEPTH_BITS - AFULL_MARGIN
// Optional (macro LEAF_RX_WORD_COUNT_EN):
//   rx_count          : accepted words since reset, wraps
//   overflow_attempt  : sticky, set when the sender offers a word while full
module leaf_user_rx_port #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned DEPTH_BITS   = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                  clk_user,
  input  logic                  reset,
  leaf_user_rx_port_if.slave    rx,
  output logic [DEPTH_BITS:0]   level,
  output logic                  afull
`ifdef LEAF_RX_WORD_COUNT_EN
  ,
  output logic [31:0]           rx_count,
  output logic                  overflow_attempt
`endif
);

  localparam int unsigned DEPTH    = 1 << DEPTH_BITS;
  localparam int unsigned CNT_W    = DEPTH_BITS + 1;
  localparam int unsigned AFULL_TH = DEPTH - AFULL_MARGIN;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } head_state_e;

  head_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d, store_cnt;
  logic [PAYLOAD_BITS-1:0] head_q;
  logic                    full, push, pop, load;

  // Full comes from the occupancy counter; a same-cycle pop never frees a slot for push.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push      = rx.vld_interface2user && !full && !reset;
  assign pop       = (state_q == S_VALID) && rx.rdy_user;
  // Words held in the RAM only (occupancy minus the head register).
  assign store_cnt = count_q - CNT_W'(state_q == S_VALID);

  assign rx.ack_user2interface = push;
  assign rx.vld_user           = (state_q == S_VALID);
  assign rx.dout_user          = head_q;
  assign level                 = count_q;

  // Head register state register.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Head next-state: load from storage whenever the head is free or being consumed.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    case (state_q)
      S_EMPTY: begin
        if (store_cnt != '0) begin
          load    = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (rx.rdy_user) begin
          if (store_cnt != '0) load    = 1'b1;
          else                 state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Pointers, occupancy, status and head data.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull    <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
      if (load) begin
        head_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
      end
      count_q <= count_d;
      afull   <= (count_d >= CNT_W'(AFULL_TH));
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_user) begin
    if (push) mem[wr_ptr_q] <= rx.dout_leaf_interface2user;
  end

`ifdef LEAF_RX_WORD_COUNT_EN
  // Accepted-word counter and sticky overflow-attempt flag.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      rx_count         <= '0;
      overflow_attempt <= 1'b0;
    end else begin
      if (push) rx_count <= rx_count + 32'd1;
      if (rx.vld_interface2user && full) overflow_attempt <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_user_rx_port.sv
// Self-checking bench for leaf_user_rx_port: a directed vector table for the
// single-word case plus hand-written sequences for fill, full-with-pop,
// streaming and mid-stream reset. A scoreboard queue checks output ordering.
module tb_leaf_user_rx_port;

  logic       clk;
  logic       reset;
  logic [4:0] level;
  logic       afull;
`ifdef LEAF_RX_WORD_COUNT_EN
  logic [31:0] rx_count;
  logic        overflow_attempt;
`endif

  leaf_user_rx_port_if #(.PAYLOAD_BITS(32)) bus ();

  leaf_user_rx_port #(
    .PAYLOAD_BITS(32),
    .DEPTH_BITS  (4),
    .AFULL_MARGIN(2)
  ) dut (
    .clk_user        (clk),
    .reset           (reset),
    .rx              (bus),
    .level           (level),
    .afull           (afull)
`ifdef LEAF_RX_WORD_COUNT_EN
    ,
    .rx_count        (rx_count),
    .overflow_attempt(overflow_attempt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rcv      = 0;

  logic [31:0] exp_q[$];
  logic [31:0] send_q[$];

  logic        s_ack, s_vld, s_afull;
  logic [31:0] s_dout;
  logic [4:0]  s_level;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        e_ack;
    logic        e_vld;
    logic [31:0] e_dout;
    logic [4:0]  e_level;
    logic        e_afull;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, then wait for the edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    bus.vld_interface2user       = v;
    bus.dout_leaf_interface2user = d;
    bus.rdy_user                 = r;
    #1;
    s_ack   = bus.ack_user2interface;
    s_vld   = bus.vld_user;
    s_dout  = bus.dout_user;
    s_level = level;
    s_afull = afull;
    if (s_vld && r) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", s_dout, 32'hFFFF_FFFF);
      else chk("sb_order", s_dout, exp_q.pop_front());
      rcv++;
    end
    if (s_ack) exp_q.push_back(d);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned rcv0;

    // Single word: push DEADBEEF, visible one cycle after the push edge, then popped.
    tbl[0] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0,          5'd0, 1'b0};
    tbl[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,          5'd1, 1'b0};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF,  5'd1, 1'b0};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,          5'd0, 1'b0};

    // Reset with the sender already offering a word: nothing may be acked.
    reset = 1'b1;
    bus.vld_interface2user       = 1'b1;
    bus.dout_leaf_interface2user = 32'h1234_5678;
    bus.rdy_user                 = 1'b1;
    #12;
    chk("rst_ack",   32'(bus.ack_user2interface), 32'd0);
    chk("rst_vld",   32'(bus.vld_user), 32'd0);
    chk("rst_dout",  bus.dout_user, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
`ifdef LEAF_RX_WORD_COUNT_EN
    chk("rst_rx_count", rx_count, 32'd0);
    chk("rst_ovf",      32'(overflow_attempt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    bus.vld_interface2user = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_ack", i),   32'(s_ack),   32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_vld", i),   32'(s_vld),   32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_level", i), 32'(s_level), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_afull", i), 32'(s_afull), 32'(tbl[i].e_afull));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_dout", i), s_dout, tbl[i].e_dout);
    end

    // Fill: 20 words offered with the kernel stalled; the sender holds each until acked.
    for (int i = 0; i < 20; i++) send_q.push_back(32'(i));
    rcv0 = rcv;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, send_q[0], 1'b0);
      chk($sformatf("fill%0d_ack", i),   32'(s_ack),   32'(i < 16));
      chk($sformatf("fill%0d_level", i), 32'(s_level), (i < 16) ? 32'(i) : 32'd16);
      chk($sformatf("fill%0d_afull", i), 32'(s_afull), 32'(((i < 16) ? i : 16) >= 14));
      if (s_ack) void'(send_q.pop_front());
    end
    chk("fill_pending", 32'(send_q.size()), 32'd4);
    chk("fill_head_vld",  32'(bus.vld_user), 32'd1);
    chk("fill_head_dout", bus.dout_user, 32'd0);
`ifdef LEAF_RX_WORD_COUNT_EN
    chk("fill_rx_count", rx_count, 32'd16);
    chk("fill_ovf",      32'(overflow_attempt), 32'd1);
`endif

    // Full with simultaneous pop: no push-through, slot frees on the next cycle.
    cycle(1'b1, send_q[0], 1'b1);
    chk("fullpop_ack",   32'(s_ack),   32'd0);
    chk("fullpop_level", 32'(s_level), 32'd16);
    cycle(1'b1, send_q[0], 1'b1);
    chk("fullpop_next_ack",   32'(s_ack),   32'd1);
    chk("fullpop_next_level", 32'(s_level), 32'd15);
    if (s_ack) void'(send_q.pop_front());
    for (int i = 0; i < 60; i++) begin
      if (send_q.size() > 0) begin
        cycle(1'b1, send_q[0], 1'b1);
        if (s_ack) void'(send_q.pop_front());
      end else begin
        cycle(1'b0, 32'h0, 1'b1);
      end
    end
    chk("fill_sent_all", 32'(send_q.size()), 32'd0);
    chk("fill_rcv",      32'(rcv - rcv0), 32'd20);
    chk("fill_end_level", 32'(level), 32'd0);
    chk("fill_end_vld",   32'(bus.vld_user), 32'd0);

    // Streaming: one word per cycle. With the one-cycle fall-through latency,
    // steady state is one word in the head plus one in storage.
    rcv0 = rcv;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h1000 + 32'(i), 1'b1);
      chk($sformatf("stream%0d_ack", i), 32'(s_ack), 32'd1);
      if (i >= 2) chk($sformatf("stream%0d_level", i), 32'(s_level), 32'd2);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    chk("stream_rcv",   32'(rcv - rcv0), 32'd100);
    chk("stream_level", 32'(level), 32'd0);

    // Reset mid-stream with 9 words buffered.
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'hB000 + 32'(i), 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("pre_rst_level", 32'(s_level), 32'd9);
    chk("pre_rst_vld",   32'(s_vld),   32'd1);
    @(negedge clk);
    bus.vld_interface2user       = 1'b1;
    bus.dout_leaf_interface2user = 32'hBAD0_BAD0;
    bus.rdy_user                 = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ack",   32'(bus.ack_user2interface), 32'd0);
    chk("midrst_vld",   32'(bus.vld_user), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_afull", 32'(afull), 32'd0);
`ifdef LEAF_RX_WORD_COUNT_EN
    chk("midrst_rx_count", rx_count, 32'd0);
    chk("midrst_ovf",      32'(overflow_attempt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.vld_interface2user = 1'b0;
    exp_q.delete();

    cycle(1'b1, 32'hA5A5_A5A5, 1'b1);
    chk("post_rst_ack", 32'(s_ack), 32'd1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("post_rst_vld0", 32'(s_vld), 32'd0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("post_rst_vld1", 32'(s_vld), 32'd1);
    chk("post_rst_dout", s_dout, 32'hA5A5_A5A5);
    cycle(1'b0, 32'h0, 1'b1);
    chk("post_rst_empty_vld",   32'(s_vld),   32'd0);
    chk("post_rst_empty_level", 32'(s_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
